// File: rtl/vec_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : vec_reg_file
//  Description : Vector register file with one write port and two registered
//                read ports. A two-state clear engine zeroes every entry, one
//                entry per cycle, after reset or on a clr_req pulse. Writes are
//                ignored and the read outputs are forced to 0 while the engine
//                runs.
//                Optional feature: define REGFILE_BYPASS_EN for write-first
//                behaviour on a same-cycle read/write collision. When it is
//                undefined the collision is read-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_reg_file #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr0,
  input  logic [AWIDTH-1:0] rd_addr1,
  output logic [DWIDTH-1:0] rd_data0,
  output logic [DWIDTH-1:0] rd_data1,
  input  logic              clr_req,
  output logic              busy
);

  // Clear engine state encoding
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_CLEAR = 1'b1;

  // Address bounds; one extra bit so DEPTH itself is representable
  localparam logic [AWIDTH:0]   c_DEPTH = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] c_LAST  = AWIDTH'(DEPTH - 1);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [AWIDTH-1:0] r_cnt;

  logic              w_wr_in_range;
  logic              w_rd0_in_range;
  logic              w_rd1_in_range;
  logic              w_wr_ok;
  logic [DWIDTH-1:0] w_rd0;
  logic [DWIDTH-1:0] w_rd1;

  assign w_wr_in_range  = ({1'b0, wr_addr}  < c_DEPTH);
  assign w_rd0_in_range = ({1'b0, rd_addr0} < c_DEPTH);
  assign w_rd1_in_range = ({1'b0, rd_addr1} < c_DEPTH);

  // A user write lands only when idle, not in reset, and inside the array
  assign w_wr_ok = wr_en && !rst && (r_state == c_IDLE) && w_wr_in_range;

  // State register: reset forces (or restarts) the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: clr_req only starts a clear from IDLE, never extends one
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (clr_req) begin
          w_state_nxt = c_CLEAR;
        end
      end
      c_CLEAR: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic: busy comes straight from the state register
  always_comb begin
    busy = (r_state == c_CLEAR);
  end

  // Clear counter: held at 0 in reset, loaded at clear start, walks the array
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == c_IDLE) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Storage: the clear engine has priority over (and blocks) user writes
  always_ff @(posedge clk) begin
    if (!rst && (r_state == c_CLEAR)) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read mux: out-of-range addresses read 0; optional write-first forwarding
  always_comb begin
    w_rd0 = '0;
    w_rd1 = '0;
    if (w_rd0_in_range) begin
      w_rd0 = r_mem[rd_addr0];
    end
    if (w_rd1_in_range) begin
      w_rd1 = r_mem[rd_addr1];
    end
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (rd_addr0 == wr_addr)) begin
      w_rd0 = wr_data;
    end
    if (w_wr_ok && (rd_addr1 == wr_addr)) begin
      w_rd1 = wr_data;
    end
`endif
  end

  // Registered read outputs, forced to 0 in reset and while clearing
  always_ff @(posedge clk) begin
    if (rst || (r_state == c_CLEAR)) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_data0 <= w_rd0;
      rd_data1 <= w_rd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_reg_file
//  Description : Directed self-checking bench for vec_reg_file. Two instances:
//                DEPTH=32 (main) and DEPTH=24 (non-power-of-two bounds).
//                Expected read data is queued when a read is issued and
//                compared one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_reg_file;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=32 instance signals
  logic          rst = 1'b0, wr_en = 1'b0, clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr0 = '0, rd_addr1 = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          busy;

  // DEPTH=24 instance signals
  logic          b_rst = 1'b0, b_wr_en = 1'b0, b_clr_req = 1'b0;
  logic [AW-1:0] b_wr_addr = '0, b_rd_addr0 = '0, b_rd_addr1 = '0;
  logic [DW-1:0] b_wr_data = '0;
  logic [DW-1:0] b_rd_data0, b_rd_data1;
  logic          b_busy;

  vec_reg_file #(.DWIDTH(DW), .DEPTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0),
    .rd_data1(rd_data1), .clr_req(clr_req), .busy(busy)
  );

  vec_reg_file #(.DWIDTH(DW), .DEPTH(24)) u_dut24 (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1),
    .rd_data0(b_rd_data0), .rd_data1(b_rd_data1), .clr_req(b_clr_req),
    .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: port 0/1 = dut32 rd_data0/1, port 2/3 = dut24 rd_data0/1
  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] val;
  } sb_t;
  sb_t sb_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string tag, input int port,
                           input logic [DW-1:0] val);
    sb_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the outputs just produced
  task automatic sb_drain();
    sb_t           e;
    logic [DW-1:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.port)
        0:       obs = rd_data0;
        1:       obs = rd_data1;
        2:       obs = b_rd_data0;
        default: obs = b_rd_data1;
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // Counts busy-high samples on dut32, starting from 'start' already seen.
  // Optionally pulses clr_req or rst when the count reaches a given value.
  task automatic count_busy(input int start, input int clr_at, input int rst_at,
                            output int n);
    n = start;
    while (n < 200) begin
      clr_req = (n == clr_at);
      rst     = (n == rst_at);
      tick();
      clr_req = 1'b0;
      rst     = 1'b0;
      if (busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    int nb;
    logic [DW-1:0] coll_exp;

    // ---------------- Reset and clear timing ----------------
    rst   = 1'b1;
    b_rst = 1'b1;
    tick();
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_rd0", rd_data0, '0);
    check("rst_rd1", rd_data1, '0);
    check("rst_busy24", {63'd0, b_busy}, 64'd1);
    b_rst = 1'b0;
    // Run dut24's count alongside dut32's
    fork
      count_busy(1, -1, -1, n);
      begin
        nb = 1;
        while (b_busy && nb < 200) begin
          tick();
          if (b_busy) nb++;
        end
      end
    join
    check("rst_busy_cycles", 64'(n), 64'd32);
    check("rst_busy_cycles24", 64'(nb), 64'd24);

    rd_addr0 = 5'd0;  rd_addr1 = 5'd17;
    expect_rd("clr_rd_a0", 0, '0);
    expect_rd("clr_rd_a17", 1, '0);
    tick(); sb_drain();
    rd_addr0 = 5'd31;
    expect_rd("clr_rd_a31", 0, '0);
    tick(); sb_drain();

    // ---------------- Basic write and read ----------------
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    wr_en = 1'b0;
    rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    expect_rd("basic_rd0", 0, 64'hDEAD_BEEF_0000_0001);
    expect_rd("basic_rd1", 1, 64'hDEAD_BEEF_0000_0001);
    tick(); sb_drain();

    // ---------------- Read/write collision ----------------
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h11;
    tick();
    wr_data = 64'h22; rd_addr0 = 5'd9; rd_addr1 = 5'd5;
`ifdef REGFILE_BYPASS_EN
    coll_exp = 64'h22;
`else
    coll_exp = 64'h11;
`endif
    expect_rd("coll_rd0", 0, coll_exp);
    expect_rd("coll_other_rd1", 1, 64'hDEAD_BEEF_0000_0001);
    tick(); sb_drain();
    wr_en = 1'b0;
    expect_rd("coll_after_rd0", 0, 64'h22);
    tick(); sb_drain();

    // ---------------- Write blocked during clear, clr_req ignored ----------------
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy", {63'd0, busy}, 64'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hFF; rd_addr0 = 5'd5;
    expect_rd("busy_rd0_zero", 0, '0);
    tick(); sb_drain();
    wr_en = 1'b0;
    count_busy(2, 10, -1, n);
    check("clr_busy_cycles", 64'(n), 64'd32);
    rd_addr0 = 5'd3; rd_addr1 = 5'd5;
    expect_rd("blocked_wr_a3", 0, '0);
    expect_rd("cleared_a5", 1, '0);
    tick(); sb_drain();

    // ---------------- Reset mid-clear ----------------
    // Write a marker first so the restarted clear is seen to zero it
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hABCD;
    tick();
    wr_en = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    count_busy(1, -1, 20, n);
    check("rst_mid_busy_cycles", 64'(n), 64'd52);
    rd_addr0 = 5'd31; rd_addr1 = 5'd0;
    expect_rd("rst_mid_a31", 0, '0);
    expect_rd("rst_mid_a0", 1, '0);
    tick(); sb_drain();

    // ---------------- Non-power-of-two depth (24) ----------------
    b_wr_en = 1'b1; b_wr_addr = 5'd25; b_wr_data = 64'h5A;
    tick();
    b_wr_addr = 5'd23; b_wr_data = 64'h77;
    tick();
    b_wr_en = 1'b0;
    b_rd_addr0 = 5'd25; b_rd_addr1 = 5'd23;
    expect_rd("d24_rd_a25", 2, '0);
    expect_rd("d24_rd_a23", 3, 64'h77);
    tick(); sb_drain();
    b_rd_addr0 = 5'd1; b_rd_addr1 = 5'd0;
    expect_rd("d24_rd_a1", 2, '0);
    expect_rd("d24_rd_a0", 3, '0);
    tick(); sb_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_reg_file.md
VEC_REG_FILE -- requirements
Module: vec_reg_file

Interface
REQ-001 The block SHALL expose parameter DWIDTH, default 64, as the data bits per entry.
REQ-002 The block SHALL expose parameter DEPTH, default 32, as the number of entries; any value from 2 to 1024 is legal, including non-powers of two.
REQ-003 The block SHALL expose parameter AWIDTH, default $clog2(DEPTH), as the address width.
REQ-004 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-005 Port clk: input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port wr_en: input, 1 bit, write strobe.
REQ-008 Port wr_addr: input, AWIDTH bits, write address.
REQ-009 Port wr_data: input, DWIDTH bits, write data.
REQ-010 Port rd_addr0: input, AWIDTH bits, read address for port 0; port rd_addr1 SHALL be identical for port 1.
REQ-011 Port rd_data0: output, DWIDTH bits, registered read data for port 0; port rd_data1 SHALL be identical for port 1.
REQ-012 Port clr_req: input, 1 bit, single-cycle request to zero all entries.
REQ-013 Port busy: output, 1 bit, high while the clear engine runs.

Function
REQ-014 Both read ports SHALL be independent, with latency 1: rd_dataN at edge k+1 equals the entry at rd_addrN sampled at edge k.
REQ-015 A write with wr_en=1 and busy=0 SHALL update the entry at wr_addr at the rising edge.
REQ-016 A read with rd_addrN >= DEPTH SHALL return 0.
REQ-017 A write with wr_addr >= DEPTH SHALL be dropped with no side effect.
REQ-018 The clear engine SHALL have two states: IDLE and CLEAR.
REQ-019 IDLE -> CLEAR SHALL occur on rst=1 or on clr_req=1 in IDLE; the clear counter SHALL be loaded with 0.
REQ-020 In CLEAR the block SHALL write 0 to entry[counter] and increment the counter once per cycle.
REQ-021 CLEAR -> IDLE SHALL occur in the cycle after entry DEPTH-1 is written, so busy is high for exactly DEPTH cycles.
REQ-022 busy SHALL equal (state == CLEAR), driven from a register.
REQ-023 While busy=1, wr_en SHALL be ignored and both rd_data outputs SHALL be forced to 0 on the next edge.
REQ-024 clr_req asserted while busy=1 SHALL be ignored; it SHALL NOT restart or extend the clear.
REQ-025 rd_data outputs SHALL change only on clock edges; there SHALL be no combinational path from any input to any output.

Reset
REQ-026 On rst=1 at an edge, rd_data0 and rd_data1 SHALL become 0, the state SHALL become CLEAR, and the counter SHALL become 0.
REQ-027 busy SHALL read 1 from the edge at which rst is sampled high.
REQ-028 rst held high SHALL keep the counter at 0.
REQ-029 A clear SHALL complete DEPTH cycles after rst deasserts.
REQ-030 rst asserted mid-clear SHALL restart the clear from entry 0.
REQ-031 The block SHALL use no initial blocks for storage; the memory contents SHALL be defined only by the clear engine.

Configuration
REQ-032 With macro REGFILE_BYPASS_EN defined, a read with wr_en=1, busy=0, rd_addrN == wr_addr and wr_addr < DEPTH in the same cycle SHALL return wr_data on the next edge (write-first).
REQ-033 With REGFILE_BYPASS_EN undefined, the same collision SHALL return the pre-write entry value (read-first).
REQ-034 In both modes, the stored value after the collision SHALL be wr_data.

Verification
REQ-035 Reset and clear timing, DEPTH=32: pulse rst for 1 cycle -> busy=1 for exactly 32 cycles; afterwards reads of addresses 0, 17 and 31 return 0.
REQ-036 Basic write and read: write 0xDEAD_BEEF_0000_0001 to addr 5; next cycle set rd_addr0=5 and rd_addr1=5 -> both rd_data equal that value one cycle later.
REQ-037 Read/write collision: addr 9 holds 0x11; same cycle write 0x22 to addr 9 with rd_addr0=9 -> rd_data0=0x22 with REGFILE_BYPASS_EN defined, 0x11 without it; a following read returns 0x22 in both builds.
REQ-038 Write blocked during clear: clr_req, then wr_en to addr 3 with 0xFF during busy -> after busy falls, addr 3 reads 0; clr_req at the 10th busy cycle -> busy still totals 32 cycles.
REQ-039 Reset mid-clear: rst at the 20th busy cycle -> busy stays high 32 more cycles after rst deasserts.
REQ-040 Non-power-of-two depth, DEPTH=24: write 0x5A to addr 25 -> dropped; read addr 25 returns 0; addr 23 is written and read back correctly.
